// File: rtl/axil_simd_rd.sv
// AXI4-lite read broadcaster: one upstream read is replicated to M_COUNT lanes and the
// lane responses are merged into a single upstream response with optional divergence check.
module axil_simd_rd #(
    parameter int unsigned M_COUNT     = 8,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHECK_MATCH = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [M_COUNT*ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [M_COUNT*3-1:0]            m_axil_arprot,
    output logic [M_COUNT-1:0]              m_axil_arvalid,
    input  logic [M_COUNT-1:0]              m_axil_arready,
    input  logic [M_COUNT*DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [M_COUNT*2-1:0]            m_axil_rresp,
    input  logic [M_COUNT-1:0]              m_axil_rvalid,
    output logic [M_COUNT-1:0]              m_axil_rready
);

    typedef enum logic [2:0] {
        StIdle    = 3'b001,
        StCollect = 3'b010,
        StResp    = 3'b100
    } state_t;

    state_t                          state_q, state_d;
    logic                            s_arready_q, s_arready_d;
    logic                            s_rvalid_q, s_rvalid_d;
    logic [DATA_WIDTH-1:0]           s_rdata_q, s_rdata_d;
    logic [1:0]                      s_rresp_q, s_rresp_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [2:0]                      prot_q, prot_d;
    logic [M_COUNT-1:0]              m_arvalid_q, m_arvalid_d;
    logic [M_COUNT-1:0]              m_rready_q, m_rready_d;
    logic [M_COUNT-1:0]              mask_q, mask_d;
    logic [M_COUNT*DATA_WIDTH-1:0]   lane_data_q, lane_data_d;
    logic [M_COUNT*2-1:0]            lane_resp_q, lane_resp_d;

    logic [M_COUNT-1:0]              cap;
    logic [1:0]                      merged_resp;
    logic                            mismatch;

    always_comb begin
        state_d     = state_q;
        s_arready_d = s_arready_q;
        s_rvalid_d  = s_rvalid_q;
        s_rdata_d   = s_rdata_q;
        s_rresp_d   = s_rresp_q;
        addr_d      = addr_q;
        prot_d      = prot_q;
        m_arvalid_d = m_arvalid_q;
        m_rready_d  = m_rready_q;
        mask_d      = mask_q;
        lane_data_d = lane_data_q;
        lane_resp_d = lane_resp_q;
        merged_resp = 2'b00;
        mismatch    = 1'b0;

        cap = m_axil_rvalid & m_rready_q;
        for (int i = 0; i < int'(M_COUNT); i++) begin
            if (cap[i]) begin
                lane_data_d[i*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                lane_resp_d[i*2 +: 2]                   = m_axil_rresp[i*2 +: 2];
            end
        end

        // Merge over the captured set including this cycle's captures.
        for (int i = 0; i < int'(M_COUNT); i++) begin
            if (lane_resp_d[i*2 +: 2] > merged_resp) begin
                merged_resp = lane_resp_d[i*2 +: 2];
            end
            if (lane_data_d[i*DATA_WIDTH +: DATA_WIDTH] != lane_data_d[DATA_WIDTH-1:0]) begin
                mismatch = 1'b1;
            end
        end
        if ((CHECK_MATCH != 0) && mismatch && (merged_resp < 2'b10)) begin
            merged_resp = 2'b10;
        end

        unique case (state_q)
            StIdle: begin
                s_arready_d = 1'b1;
                if (s_axil_arvalid && s_arready_q) begin
                    addr_d      = s_axil_araddr;
                    prot_d      = s_axil_arprot;
                    m_arvalid_d = '1;
                    m_rready_d  = '1;
                    mask_d      = '0;
                    s_arready_d = 1'b0;
                    state_d     = StCollect;
                end
            end
            StCollect: begin
                m_arvalid_d = m_arvalid_q & ~m_axil_arready;
                m_rready_d  = m_rready_q & ~cap;
                mask_d      = mask_q | cap;
                if (&mask_d) begin
                    s_rvalid_d = 1'b1;
                    s_rdata_d  = lane_data_d[DATA_WIDTH-1:0];
                    s_rresp_d  = merged_resp;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (s_axil_rready) begin
                    s_rvalid_d  = 1'b0;
                    s_arready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s_arready_q <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_rdata_q   <= '0;
            s_rresp_q   <= '0;
            addr_q      <= '0;
            prot_q      <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            mask_q      <= '0;
            lane_data_q <= '0;
            lane_resp_q <= '0;
        end else begin
            state_q     <= state_d;
            s_arready_q <= s_arready_d;
            s_rvalid_q  <= s_rvalid_d;
            s_rdata_q   <= s_rdata_d;
            s_rresp_q   <= s_rresp_d;
            addr_q      <= addr_d;
            prot_q      <= prot_d;
            m_arvalid_q <= m_arvalid_d;
            m_rready_q  <= m_rready_d;
            mask_q      <= mask_d;
            lane_data_q <= lane_data_d;
            lane_resp_q <= lane_resp_d;
        end
    end

    assign s_axil_arready = s_arready_q;
    assign s_axil_rvalid  = s_rvalid_q;
    assign s_axil_rdata   = s_rdata_q;
    assign s_axil_rresp   = s_rresp_q;
    assign m_axil_araddr  = {M_COUNT{addr_q}};
    assign m_axil_arprot  = {M_COUNT{prot_q}};
    assign m_axil_arvalid = m_arvalid_q;
    assign m_axil_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_simd_rd.sv
// Bench for axil_simd_rd: four behavioural lane slaves with programmable stalls, and a
// reference model giving expected latency, per-lane handshake windows and merged response.
module tb_axil_simd_rd;

    localparam int NL = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     s_araddr = '0;
    logic [2:0]        s_arprot = '0;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready = 1'b0;
    logic [NL*AW-1:0]  m_araddr;
    logic [NL*3-1:0]   m_arprot;
    logic [NL-1:0]     m_arvalid;
    logic [NL-1:0]     m_arready = '0;
    logic [NL*DW-1:0]  m_rdata = '0;
    logic [NL*2-1:0]   m_rresp = '0;
    logic [NL-1:0]     m_rvalid = '0;
    logic [NL-1:0]     m_rready;

    logic              nc_arready;
    logic [DW-1:0]     nc_rdata;
    logic [1:0]        nc_rresp;
    logic              nc_rvalid;
    logic [NL*AW-1:0]  nc_m_araddr;
    logic [NL*3-1:0]   nc_m_arprot;
    logic [NL-1:0]     nc_m_arvalid;
    logic [NL-1:0]     nc_m_rready;

    int errors = 0;
    int checks = 0;

    // Lane slave model state
    int          ar_delay [NL];
    int          r_delay  [NL];
    logic [31:0] ldata    [NL];
    logic [1:0]  lresp    [NL];
    int          ar_cnt   [NL];
    int          r_cnt    [NL];
    bit          ar_done  [NL];
    bit          r_done   [NL];

    always #5 clk = ~clk;

    axil_simd_rd #(.M_COUNT(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHECK_MATCH(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
        .s_axil_arready(s_arready), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
        .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
        .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    axil_simd_rd #(.M_COUNT(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHECK_MATCH(0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
        .s_axil_arready(nc_arready), .s_axil_rdata(nc_rdata), .s_axil_rresp(nc_rresp),
        .s_axil_rvalid(nc_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(nc_m_araddr), .m_axil_arprot(nc_m_arprot), .m_axil_arvalid(nc_m_arvalid),
        .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(nc_m_rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) begin
            ar_cnt[i] = 0; r_cnt[i] = 0; ar_done[i] = 0; r_done[i] = 0;
        end
        m_arready = '0;
        m_rvalid  = '0;
    endtask

    task automatic set_lanes(input logic [31:0] d, input logic [1:0] r);
        for (int i = 0; i < NL; i++) begin
            ar_delay[i] = 0; r_delay[i] = 0; ldata[i] = d; lresp[i] = r;
        end
    endtask

    // Drive lane inputs for the current cycle, advance one clock, then update lane state.
    task automatic tick();
        bit arh [NL];
        bit rh  [NL];
        bit arv [NL];
        for (int i = 0; i < NL; i++) begin
            m_arready[i] = m_arvalid[i] && !ar_done[i] && (ar_cnt[i] >= ar_delay[i]);
            m_rvalid[i]  = ar_done[i] && !r_done[i] && (r_cnt[i] >= r_delay[i]);
            m_rdata[i*DW +: DW] = m_rvalid[i] ? ldata[i] : $urandom;
            m_rresp[i*2 +: 2]   = m_rvalid[i] ? lresp[i] : 2'($urandom);
            arv[i] = m_arvalid[i];
            arh[i] = m_arvalid[i] && m_arready[i];
            rh[i]  = m_rvalid[i] && m_rready[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (ar_done[i] && !r_done[i]) begin
                if (rh[i]) r_done[i] = 1;
                else       r_cnt[i]++;
            end
            if (arh[i])                      ar_done[i] = 1;
            else if (arv[i] && !ar_done[i])  ar_cnt[i]++;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int bp);
        int          arc [NL];
        int          rc  [NL];
        int          last;
        int          exp_rv;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [1:0]  er_nc;
        bit          mism;

        // Reference: lane i accepts AR at 1+ar_delay, returns R one cycle later plus r_delay.
        last = 0;
        for (int i = 0; i < NL; i++) begin
            arc[i] = 1 + ar_delay[i];
            rc[i]  = arc[i] + 1 + r_delay[i];
            if (rc[i] > last) last = rc[i];
        end
        exp_rv = last + 1;
        ed = ldata[0];
        er = 2'b00;
        mism = 0;
        for (int i = 0; i < NL; i++) begin
            if (lresp[i] > er) er = lresp[i];
            if (ldata[i] != ldata[0]) mism = 1;
        end
        er_nc = er;
        if (mism && er < 2'b10) er = 2'b10;

        for (int w = 0; w < 50 && s_arready !== 1'b1; w++) tick();
        chk("arready_idle", 64'(s_arready), 64'(1));
        clear_lanes();
        s_arvalid = 1'b1;
        s_araddr  = addr;
        s_arprot  = prot;
        tick();
        s_arvalid = 1'b0;
        s_araddr  = $urandom;
        s_arprot  = 3'($urandom);

        for (int c = 1; c <= exp_rv; c++) begin
            chk("rvalid_timing", 64'(s_rvalid), 64'(c == exp_rv));
            chk("arready_busy", 64'(s_arready), 64'(0));
            for (int i = 0; i < NL; i++) begin
                chk("m_arvalid", 64'(m_arvalid[i]), 64'(c <= arc[i]));
                chk("m_rready", 64'(m_rready[i]), 64'(c <= rc[i]));
                chk("nc_m_rready", 64'(nc_m_rready[i]), 64'(c <= rc[i]));
                if (c == 1) begin
                    chk("m_araddr", 64'(m_araddr[i*AW +: AW]), 64'(addr));
                    chk("m_arprot", 64'(m_arprot[i*3 +: 3]), 64'(prot));
                    chk("nc_m_araddr", 64'(nc_m_araddr[i*AW +: AW]), 64'(addr));
                    chk("nc_m_arvalid", 64'(nc_m_arvalid[i]), 64'(1));
                    chk("nc_m_arprot", 64'(nc_m_arprot[i*3 +: 3]), 64'(prot));
                end
            end
            if (c < exp_rv) tick();
        end
        chk("rdata", 64'(s_rdata), 64'(ed));
        chk("rresp", 64'(s_rresp), 64'(er));
        chk("nc_rvalid", 64'(nc_rvalid), 64'(1));
        chk("nc_rdata", 64'(nc_rdata), 64'(ed));
        chk("nc_rresp", 64'(nc_rresp), 64'(er_nc));

        for (int b = 0; b < bp; b++) begin
            s_rready = 1'b0;
            tick();
            chk("bp_rvalid", 64'(s_rvalid), 64'(1));
            chk("bp_rdata", 64'(s_rdata), 64'(ed));
            chk("bp_rresp", 64'(s_rresp), 64'(er));
            chk("bp_arready", 64'(s_arready), 64'(0));
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("done_rvalid", 64'(s_rvalid), 64'(0));
        chk("done_arready", 64'(s_arready), 64'(1));
        chk("nc_done_arready", 64'(nc_arready), 64'(1));
    endtask

    initial begin
        logic [31:0] base;
        set_lanes(32'h0, 2'b00);
        clear_lanes();

        // Power-on reset
        #1;
        chk("rst_arready", 64'(s_arready), 64'(0));
        chk("rst_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_m_rready", 64'(m_rready), 64'(0));
        chk("rst_rdata", 64'(s_rdata), 64'(0));
        chk("rst_m_araddr", 64'(m_araddr[63:0]), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_arready0", 64'(s_arready), 64'(0));
        tick();
        chk("post_rst_arready1", 64'(s_arready), 64'(1));

        // Basic: all lanes zero-wait, same data
        set_lanes(32'hCAFE0001, 2'b00);
        do_read(32'h0000_1000, 3'b010, 0);

        // Staggered: lane 3 AR stalled 5 cycles, lane 1 R 7 cycles late
        set_lanes($urandom, 2'b00);
        ar_delay[3] = 5;
        r_delay[1]  = 7;
        do_read(32'h0000_2004, 3'b001, 0);

        // Response merge: lane 2 DECERR
        set_lanes(32'h5555_AAAA, 2'b00);
        lresp[2] = 2'b11;
        do_read(32'h0000_3008, 3'b000, 0);

        // Divergence: lane 1 returns 0
        set_lanes(32'h0000_1234, 2'b00);
        ldata[1] = 32'h0;
        do_read(32'h0000_400C, 3'b100, 1);

        // Back-pressure then back-to-back read
        set_lanes(32'hDEAD_BEEF, 2'b01);
        do_read(32'h0000_5010, 3'b011, 10);
        set_lanes(32'h1357_9BDF, 2'b00);
        r_delay[0] = 2;
        do_read(32'h0000_5014, 3'b011, 0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            base = $urandom;
            for (int i = 0; i < NL; i++) begin
                ar_delay[i] = $urandom_range(0, 3);
                r_delay[i]  = $urandom_range(0, 3);
                ldata[i]    = ($urandom_range(0, 3) == 0) ? $urandom : base;
                lresp[i]    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            end
            do_read($urandom, 3'($urandom), $urandom_range(0, 2));
        end

        // Reset in the middle of collection
        set_lanes(32'h2468_ACE0, 2'b00);
        r_delay[0] = 20;
        clear_lanes();
        s_arvalid = 1'b1;
        s_araddr  = 32'h0000_6000;
        tick();
        s_arvalid = 1'b0;
        repeat (3) tick();
        chk("mid_collect_rready0", 64'(m_rready[0]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("abort_m_rready", 64'(m_rready), 64'(0));
        chk("abort_rvalid", 64'(s_rvalid), 64'(0));
        chk("abort_arready", 64'(s_arready), 64'(0));
        chk("abort_m_araddr", 64'(m_araddr[31:0]), 64'(0));
        clear_lanes();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rerst_arready0", 64'(s_arready), 64'(0));
        tick();
        chk("rerst_arready1", 64'(s_arready), 64'(1));

        set_lanes(32'hCAFE0001, 2'b00);
        do_read(32'h0000_7000, 3'b000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
